// File: rtl/io_periph.sv
// Memory-mapped I/O block for the 16-bit single-cycle CPU: LEDs, six 7-segment
// displays, debounced switches, a prescaled timer and sticky event flags.
module io_periph #(
    parameter logic [15:0] BASE            = 16'hFF00,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] PRESCALE        = 16'd50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        hit,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDS,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3,
    output logic [7:0]  HEX4,
    output logic [7:0]  HEX5,
    output logic        irq
);

    // Bus: no handshake or backpressure. A store commits on the CLK edge where
    // we=1 and hit=1; a load is answered combinationally in the same cycle.
    logic [15:0] off;
    logic [2:0]  reg_sel;
    logic        wr;

    assign off     = addr - BASE;
    assign hit     = (off[15:3] == 13'd0);
    assign reg_sel = off[2:0];
    assign wr      = we && hit;

    logic wr_led, wr_hexlo, wr_hexhi, wr_blank, wr_count, wr_cmp, wr_status;

    assign wr_led    = wr && (reg_sel == 3'd0);
    assign wr_hexlo  = wr && (reg_sel == 3'd1);
    assign wr_hexhi  = wr && (reg_sel == 3'd2);
    assign wr_blank  = wr && (reg_sel == 3'd3);
    assign wr_count  = wr && (reg_sel == 3'd5);
    assign wr_cmp    = wr && (reg_sel == 3'd6);
    assign wr_status = wr && (reg_sel == 3'd7);

    logic [9:0]  led;
    logic [15:0] hex_lo;
    logic [7:0]  hex_hi;
    logic [5:0]  blank;
    logic [15:0] cmp;

    always_ff @(posedge CLK) begin
        if (RST) begin
            led    <= 10'd0;
            hex_lo <= 16'd0;
            hex_hi <= 8'd0;
            blank  <= 6'h3F;
            cmp    <= 16'hFFFF;
        end else begin
            if (wr_led)   led    <= wdata[9:0];
            if (wr_hexlo) hex_lo <= wdata;
            if (wr_hexhi) hex_hi <= wdata[7:0];
            if (wr_blank) blank  <= wdata[5:0];
            if (wr_cmp)   cmp    <= wdata;
        end
    end

    // Switch path: two-flop synchroniser followed by a stability counter.
    logic [9:0]  sw_meta;
    logic [9:0]  sw_sync;
    logic [9:0]  sw_db;
    logic [15:0] db_cnt;
    logic        sw_mismatch;
    logic        sw_changed;

    assign sw_mismatch = (sw_sync != sw_db);
    assign sw_changed  = sw_mismatch && (db_cnt == DEBOUNCE_CYCLES - 16'd1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_meta <= 10'd0;
            sw_sync <= 10'd0;
            sw_db   <= 10'd0;
            db_cnt  <= 16'd0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
            if (sw_changed) begin
                sw_db  <= sw_sync;
                db_cnt <= 16'd0;
            end else if (sw_mismatch) begin
                db_cnt <= db_cnt + 16'd1;
            end else begin
                db_cnt <= 16'd0;
            end
        end
    end

    // Timer: a COUNT write outranks a tick on the same edge, and so blocks the match.
    logic [15:0] presc;
    logic [15:0] count;
    logic [15:0] count_inc;
    logic        tick;
    logic        timer_match;

    assign tick        = (presc == PRESCALE - 16'd1);
    assign count_inc   = count + 16'd1;
    assign timer_match = !wr_count && tick && (count_inc == cmp);

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc <= 16'd0;
            count <= 16'd0;
        end else if (wr_count) begin
            presc <= 16'd0;
            count <= 16'd0;
        end else if (tick) begin
            presc <= 16'd0;
            count <= count_inc;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // Sticky flags: a set event on the same edge as its write-1-to-clear wins.
    logic [1:0] status;
    logic [1:0] status_clr;

    assign status_clr = wr_status ? wdata[1:0] : 2'b00;

    always_ff @(posedge CLK) begin
        if (RST) status <= 2'b00;
        else     status <= (status & ~status_clr) | {sw_changed, timer_match};
    end

    assign irq = status[0] | status[1];

    always_comb begin
        rdata = 16'd0;
        if (hit) begin
            case (reg_sel)
                3'd0: rdata = {6'd0, led};
                3'd1: rdata = hex_lo;
                3'd2: rdata = {8'd0, hex_hi};
                3'd3: rdata = {10'd0, blank};
                3'd4: rdata = {6'd0, sw_db};
                3'd5: rdata = count;
                3'd6: rdata = cmp;
                3'd7: rdata = {14'd0, status};
            endcase
        end
    end

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'hC0;
            4'h1: seg7 = 8'hF9;
            4'h2: seg7 = 8'hA4;
            4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;
            4'h5: seg7 = 8'h92;
            4'h6: seg7 = 8'h82;
            4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;
            4'h9: seg7 = 8'h90;
            4'hA: seg7 = 8'h88;
            4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;
            4'hD: seg7 = 8'hA1;
            4'hE: seg7 = 8'h86;
            4'hF: seg7 = 8'h8E;
        endcase
    endfunction

    assign LEDS = led;
    assign HEX0 = blank[0] ? 8'hFF : seg7(hex_lo[3:0]);
    assign HEX1 = blank[1] ? 8'hFF : seg7(hex_lo[7:4]);
    assign HEX2 = blank[2] ? 8'hFF : seg7(hex_lo[11:8]);
    assign HEX3 = blank[3] ? 8'hFF : seg7(hex_lo[15:12]);
    assign HEX4 = blank[4] ? 8'hFF : seg7(hex_hi[3:0]);
    assign HEX5 = blank[5] ? 8'hFF : seg7(hex_hi[7:4]);

endmodule

// File: tb/tb_io_periph.sv
// Bench for io_periph: vector table for the register map, hand sequences for
// debounce/timer corner cases, then random bus traffic against a reference model.
module tb_io_periph;

    logic        CLK;
    logic        RST;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        hit;
    logic [9:0]  SW;
    logic [9:0]  LEDS;
    logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic        irq;

    io_periph #(
        .BASE(16'hFF00),
        .DEBOUNCE_CYCLES(16'd4),
        .PRESCALE(16'd3)
    ) dut (
        .CLK(CLK), .RST(RST), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata), .hit(hit), .SW(SW), .LEDS(LEDS),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .irq(irq)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int edge_n = 0;
    always @(posedge CLK) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge CLK);
        addr = a; we = 1'b1; wdata = d;
        @(posedge CLK);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic h);
        @(negedge CLK);
        addr = a; we = 1'b0;
        #1;
        d = rdata;
        h = hit;
    endtask

    // reference model state
    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [9:0]  m_led;
    logic [15:0] m_hexlo;
    logic [7:0]  m_hexhi;
    logic [5:0]  m_blank;
    logic [15:0] m_cmp;
    logic [9:0]  m_sw;
    int          m_clear_edge;

    function automatic logic [7:0] m_hex(input int i);
        logic [3:0] nib;
        nib = (i < 4) ? m_hexlo[4*i +: 4] : m_hexhi[4*(i-4) +: 4];
        return m_blank[i] ? 8'hFF : seg_tab[nib];
    endfunction

    function automatic logic [15:0] m_count();
        return 16'((edge_n - m_clear_edge) / 3);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] r);
        case (r)
            3'd0: return {6'd0, m_led};
            3'd1: return m_hexlo;
            3'd2: return {8'd0, m_hexhi};
            3'd3: return {10'd0, m_blank};
            3'd4: return {6'd0, m_sw};
            3'd5: return m_count();
            3'd6: return m_cmp;
            default: return 16'd0;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " outs"}, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, LEDS},
              {m_hex(5), m_hex(4), m_hex(3), m_hex(2), m_hex(1), m_hex(0), m_led});
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_hit;
        logic [9:0]  exp_leds;
    } vec_t;

    vec_t vecs [21];

    task automatic apply_vecs(input int lo, input int hi);
        logic [15:0] d;
        logic        h;
        for (int i = lo; i < hi; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
                check($sformatf("vec%0d leds", i), LEDS, vecs[i].exp_leds);
            end else begin
                bus_read(vecs[i].addr, d, h);
                check($sformatf("vec%0d rdata", i), d, vecs[i].exp_rd);
                check($sformatf("vec%0d hit", i), h, vecs[i].exp_hit);
            end
        end
    endtask

    initial begin
        logic [15:0] d;
        logic        h;
        logic [9:0]  sw_r;

        vecs[0]  = '{16'hFF01, 1'b1, 16'h3A7F, 16'h0000, 1'b1, 10'h000};
        vecs[1]  = '{16'hFF02, 1'b1, 16'h0012, 16'h0000, 1'b1, 10'h000};
        vecs[2]  = '{16'hFF03, 1'b1, 16'h0000, 16'h0000, 1'b1, 10'h000};
        vecs[3]  = '{16'hFF01, 1'b0, 16'h0000, 16'h3A7F, 1'b1, 10'h000};
        vecs[4]  = '{16'hFF02, 1'b0, 16'h0000, 16'h0012, 1'b1, 10'h000};
        vecs[5]  = '{16'hFF03, 1'b0, 16'h0000, 16'h0000, 1'b1, 10'h000};
        vecs[6]  = '{16'hFF00, 1'b1, 16'h0000, 16'h0000, 1'b1, 10'h000};
        vecs[7]  = '{16'hFF08, 1'b1, 16'h03FF, 16'h0000, 1'b0, 10'h000};
        vecs[8]  = '{16'hFEFF, 1'b1, 16'h03FF, 16'h0000, 1'b0, 10'h000};
        vecs[9]  = '{16'hFF08, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000};
        vecs[10] = '{16'hFEFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000};
        vecs[11] = '{16'hFF00, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 10'h3FF};
        vecs[12] = '{16'hFF00, 1'b0, 16'h0000, 16'h03FF, 1'b1, 10'h3FF};
        vecs[13] = '{16'hFF04, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 10'h3FF};
        vecs[14] = '{16'hFF04, 1'b0, 16'h0000, 16'h0000, 1'b1, 10'h3FF};
        vecs[15] = '{16'hFF02, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 10'h3FF};
        vecs[16] = '{16'hFF02, 1'b0, 16'h0000, 16'h00FF, 1'b1, 10'h3FF};
        vecs[17] = '{16'hFF03, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 10'h3FF};
        vecs[18] = '{16'hFF03, 1'b0, 16'h0000, 16'h003F, 1'b1, 10'h3FF};
        vecs[19] = '{16'hFF00, 1'b1, 16'h0155, 16'h0000, 1'b1, 10'h155};
        vecs[20] = '{16'hFF00, 1'b0, 16'h0000, 16'h0155, 1'b1, 10'h155};

        RST = 1'b1; addr = 16'h0000; we = 1'b0; wdata = 16'h0000; SW = 10'h000;

        // reset
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("rst leds", LEDS, 10'h000);
        check("rst hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, 48'hFFFF_FFFF_FFFF);
        check("rst irq", irq, 1'b0);
        bus_read(16'hFF06, d, h); check("rst cmp", d, 16'hFFFF);
        bus_read(16'hFF03, d, h); check("rst blank", d, 16'h003F);
        bus_read(16'hFF07, d, h); check("rst status", d, 16'h0000);

        // display
        apply_vecs(0, 6);
        check("disp hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, 48'hF9A4_B088_F88E);
        bus_write(16'hFF03, 16'h0001);
        check("blank0 hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, 48'hF9A4_B088_F8FF);

        // address window and read masking
        apply_vecs(6, 21);

        // debounce: value lands on the 6th edge after SW changes
        @(negedge CLK);
        SW = 10'h155; addr = 16'hFF04; we = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge CLK);
            #1;
            if (k == 5) check("db early", rdata, 16'h0000);
            if (k == 6) begin
                check("db load", rdata, 16'h0155);
                check("db irq", irq, 1'b1);
            end
        end
        repeat (4) @(posedge CLK);
        bus_read(16'hFF04, d, h); check("db hold", d, 16'h0155);
        bus_read(16'hFF07, d, h); check("db status", d, 16'h0002);
        bus_write(16'hFF07, 16'h0002);
        check("db w1c irq", irq, 1'b0);
        @(negedge CLK);
        SW = 10'h000;
        repeat (3) @(negedge CLK);
        SW = 10'h155;
        repeat (10) @(negedge CLK);
        bus_read(16'hFF04, d, h); check("glitch sw", d, 16'h0155);
        bus_read(16'hFF07, d, h); check("glitch status", d, 16'h0000);

        // timer: match on the 9th edge after clear with CMP=3
        bus_write(16'hFF06, 16'h0003);
        bus_write(16'hFF05, 16'h0000);
        addr = 16'hFF05;
        for (int k = 1; k <= 9; k++) begin
            @(posedge CLK);
            #1;
            if (k == 8) begin
                check("tmr cnt8", rdata, 16'h0002);
                check("tmr irq8", irq, 1'b0);
            end
            if (k == 9) begin
                check("tmr cnt9", rdata, 16'h0003);
                check("tmr irq9", irq, 1'b1);
            end
        end
        bus_read(16'hFF07, d, h); check("tmr status", d, 16'h0001);

        // COUNT clear on a tick edge: clear wins
        bus_write(16'hFF07, 16'h0001);
        bus_write(16'hFF05, 16'h0000);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        addr = 16'hFF05; we = 1'b1; wdata = 16'h0000;
        @(posedge CLK);
        #1;
        we = 1'b0;
        check("clr vs tick", rdata, 16'h0000);

        // W1C on the same edge as a match: set wins
        bus_write(16'hFF07, 16'h0001);
        check("pre match irq", irq, 1'b0);
        repeat (7) @(posedge CLK);
        @(negedge CLK);
        addr = 16'hFF07; we = 1'b1; wdata = 16'h0001;
        @(posedge CLK);
        #1;
        we = 1'b0;
        check("set beats w1c", rdata, 16'h0001);
        bus_read(16'hFF05, d, h); check("match count", d, 16'h0003);
        bus_write(16'hFF07, 16'h0001);
        check("w1c irq", irq, 1'b0);

        // CMP written equal to current COUNT does not set the flag
        bus_write(16'hFF05, 16'h0000);
        bus_write(16'hFF06, 16'h0000);
        bus_read(16'hFF07, d, h); check("cmp eq no set", d, 16'h0000);

        // reset mid-prescale with COUNT already at 2
        bus_write(16'hFF05, 16'h0000);
        repeat (7) @(posedge CLK);
        sw_r = 10'($urandom_range(0, 1023));
        @(negedge CLK);
        SW = sw_r; RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        m_clear_edge = edge_n;
        m_led = 10'h000; m_hexlo = 16'h0000; m_hexhi = 8'h00; m_blank = 6'h3F;
        m_cmp = 16'hFFFF; m_sw = 10'h000;
        check_outputs("midrst");
        check("midrst irq", irq, 1'b0);
        bus_read(16'hFF05, d, h); check("midrst count", d, m_count());
        bus_read(16'hFF04, d, h); check("midrst sw", d, 16'h0000);
        repeat (12) @(negedge CLK);
        m_sw = sw_r;

        // random traffic against the model
        for (int n = 0; n < 300; n++) begin
            int          sel;
            logic [15:0] a;
            logic [15:0] v;
            sel = $urandom_range(0, 9);
            v   = 16'($urandom);
            if (sel == 7 || sel == 8) a = 16'($urandom_range(16'hFF08, 16'hFFFF));
            else if (sel == 9)        a = 16'($urandom_range(0, 16'hFEFF));
            else                      a = 16'hFF00 + 16'(sel);
            if ($urandom_range(0, 1) == 1) begin
                bus_write(a, v);
                case (sel)
                    0: m_led = v[9:0];
                    1: m_hexlo = v;
                    2: m_hexhi = v[7:0];
                    3: m_blank = v[5:0];
                    5: m_clear_edge = edge_n;
                    6: m_cmp = v;
                    default: ;
                endcase
            end else begin
                bus_read(a, d, h);
                check($sformatf("rnd%0d hit", n), h, (sel < 7));
                check($sformatf("rnd%0d rd@%h", n, a), d, (sel < 7) ? m_read(3'(sel)) : 16'h0000);
            end
            check_outputs($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
